dma_addr_page_latch: RTL and testbench

- Downstream companion of the 8237A DMA core. It rebuilds the full 24-bit system address during DMA service.
- Captures A15:A8, which the core multiplexes onto DB and qualifies with ADSTB, and joins it with core A7:A0.
- Prepends an 8-bit per-channel page register that the CPU writes.
- Flags 64K wrap within a service session and malformed DACK patterns.

---
 rtl/dma_addr_page_latch_if.sv | 31 +++
 rtl/dma_addr_page_latch.sv | 162 ++++++++++++++++
 tb/tb_dma_addr_page_latch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dma_addr_page_latch_if.sv
// Bus bundle between the 8237A-side driver (master) and the address/page latch (slave).
interface dma_addr_page_latch_if #(
  parameter int NUM_CH = 4,
  parameter int PAGE_W = 8
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [7:0]         DB;
  logic               ADSTB;
  logic               AEN;
  logic [7:0]         A;
  logic [NUM_CH-1:0]  DACK;
  logic               PG_WR;
  logic [SEL_W-1:0]   PG_SEL;
  logic [PAGE_W-1:0]  PG_DIN;
  logic [PAGE_W-1:0]  PG_DOUT;
  logic [15+PAGE_W:0] SYS_ADDR;
  logic               ADDR_VALID;
  logic               BND_CROSS;
  logic               DACK_ERR;

  modport master (
    output DB, ADSTB, AEN, A, DACK, PG_WR, PG_SEL, PG_DIN,
    input  PG_DOUT, SYS_ADDR, ADDR_VALID, BND_CROSS, DACK_ERR
  );

  modport slave (
    input  DB, ADSTB, AEN, A, DACK, PG_WR, PG_SEL, PG_DIN,
    output PG_DOUT, SYS_ADDR, ADDR_VALID, BND_CROSS, DACK_ERR
  );
endinterface

// File: rtl/dma_addr_page_latch.sv
// Rebuilds the 24-bit DMA system address {page, A15:A8, A7:A0} behind an 8237A core,
// with per-channel CPU page registers, 64K-wrap and bad-DACK flags.
module dma_addr_page_latch #(
  parameter int NUM_CH = 4,
  parameter int PAGE_W = 8
) (
  input logic CLK,
  input logic RESET,
  dma_addr_page_latch_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {S_IDLE, S_SERVICE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_aen_d;
  logic [7:0]         r_hi_latch;
  logic               r_hi_vld;
  logic [SEL_W-1:0]   r_active;
  logic               r_good;
  logic [PAGE_W-1:0]  r_page [NUM_CH];
  logic               r_pend_vld;
  logic [PAGE_W-1:0]  r_pend_data;
  logic               r_bnd;
  logic               r_err;
  logic [15+PAGE_W:0] r_sys_addr;
  logic               r_addr_valid;

  logic               w_aen_rise;
  logic [7:0]         w_next_hi;
  logic               w_onehot;
  logic [SEL_W-1:0]   w_dack_idx;
  logic [PAGE_W-1:0]  w_pg_dout;
  logic [PAGE_W-1:0]  w_page_act;
  logic               w_wr_active;
  logic               w_defer;
  logic               w_wr_direct;
  logic               w_pend_commit;
  logic               w_bnd_set;
  logic               w_err_clr;
  logic [15+PAGE_W:0] w_sys_addr_nxt;
  logic               w_addr_valid_nxt;

  assign w_aen_rise    = bus.AEN & ~r_aen_d;
  assign w_next_hi     = bus.ADSTB ? bus.DB : r_hi_latch;
  assign w_onehot      = (bus.DACK != '0) && ((bus.DACK & (bus.DACK - NUM_CH'(1))) == '0);
  assign w_wr_active   = bus.PG_WR && (bus.PG_SEL == r_active);
  // A write to the channel being serviced must not change the page mid-transfer.
  assign w_defer       = w_wr_active && (r_state == S_SERVICE) && bus.AEN;
  assign w_wr_direct   = bus.PG_WR && !w_defer;
  assign w_pend_commit = r_pend_vld && !bus.AEN;
  assign w_bnd_set     = (r_state == S_SERVICE) && bus.ADSTB && (bus.DB == 8'h00) &&
                         (r_hi_latch == 8'hFF) && r_hi_vld;
  assign w_err_clr     = bus.PG_WR && (bus.PG_SEL == '0) && (bus.PG_DIN == '0);

  always_comb begin
    w_dack_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.DACK[i]) w_dack_idx = SEL_W'(i);
  end

  always_comb begin
    w_pg_dout  = '0;
    w_page_act = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.PG_SEL == SEL_W'(i)) w_pg_dout  = r_page[i];
      if (r_active == SEL_W'(i))   w_page_act = r_page[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_aen_rise) w_state_nxt = S_SERVICE;
      S_SERVICE: if (!bus.AEN)   w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sys_addr_nxt   = '0;
    w_addr_valid_nxt = 1'b0;
    if ((r_state == S_SERVICE) && bus.AEN && r_good) begin
      w_sys_addr_nxt   = {w_page_act, w_next_hi, bus.A};
      w_addr_valid_nxt = 1'b1;
    end
  end

  // Direct writes win over a pending commit to the same channel: they are newer.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_CH; i++) r_page[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_direct && (bus.PG_SEL == SEL_W'(i)))
          r_page[i] <= bus.PG_DIN;
        else if (w_pend_commit && (r_active == SEL_W'(i)))
          r_page[i] <= r_pend_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_aen_d      <= 1'b0;
      r_hi_latch   <= '0;
      r_hi_vld     <= 1'b0;
      r_active     <= '0;
      r_good       <= 1'b0;
      r_pend_vld   <= 1'b0;
      r_pend_data  <= '0;
      r_bnd        <= 1'b0;
      r_err        <= 1'b0;
      r_sys_addr   <= '0;
      r_addr_valid <= 1'b0;
    end else begin
      r_aen_d <= bus.AEN;
      if (bus.ADSTB) r_hi_latch <= bus.DB;

      // hi_vld marks a capture made inside the current session.
      if (w_aen_rise)     r_hi_vld <= bus.ADSTB;
      else if (bus.ADSTB) r_hi_vld <= 1'b1;

      if (w_aen_rise) begin
        if (w_onehot) begin
          r_active <= w_dack_idx;
          r_good   <= 1'b1;
        end else begin
          r_good   <= 1'b0;
        end
      end

      if (w_defer) begin
        r_pend_vld  <= 1'b1;
        r_pend_data <= bus.PG_DIN;
      end else if (w_pend_commit) begin
        r_pend_vld  <= 1'b0;
      end

      if (w_aen_rise)       r_bnd <= 1'b0;
      else if (w_wr_active) r_bnd <= 1'b0;
      else if (w_bnd_set)   r_bnd <= 1'b1;

      if (w_aen_rise && !w_onehot) r_err <= 1'b1;
      else if (w_err_clr)          r_err <= 1'b0;

      r_sys_addr   <= w_sys_addr_nxt;
      r_addr_valid <= w_addr_valid_nxt;
    end
  end

  assign bus.PG_DOUT    = w_pg_dout;
  assign bus.SYS_ADDR   = r_sys_addr;
  assign bus.ADDR_VALID = r_addr_valid;
  assign bus.BND_CROSS  = r_bnd;
  assign bus.DACK_ERR   = r_err;
endmodule

// File: tb/tb_dma_addr_page_latch.sv
// Directed bench for dma_addr_page_latch: a per-cycle vector table plus hand-written
// sequences for deferred page writes and reset in mid-session.
module tb_dma_addr_page_latch;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dma_addr_page_latch_if #(.NUM_CH(4), .PAGE_W(8)) bus ();

  dma_addr_page_latch #(.NUM_CH(4), .PAGE_W(8)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        adstb;
    logic [7:0]  db;
    logic        aen;
    logic [7:0]  a;
    logic [3:0]  dack;
    logic        wr;
    logic [1:0]  sel;
    logic [7:0]  din;
    logic [23:0] e_addr;
    logic        e_vld;
    logic        e_bnd;
    logic        e_err;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic s, input logic [7:0] d,
                              input logic e, input logic [7:0] a, input logic [3:0] k,
                              input logic w, input logic [1:0] sl, input logic [7:0] di,
                              input logic [23:0] ea, input logic ev, input logic eb,
                              input logic ee, input logic [7:0] ed);
    vec_t v;
    v.rst_n = r;  v.adstb = s; v.db = d; v.aen = e; v.a = a; v.dack = k;
    v.wr = w; v.sel = sl; v.din = di;
    v.e_addr = ea; v.e_vld = ev; v.e_bnd = eb; v.e_err = ee; v.e_dout = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one edge pass, then compare all outputs.
  task automatic step(input vec_t v, input string tag);
    rst_n      = v.rst_n;
    bus.ADSTB  = v.adstb;
    bus.DB     = v.db;
    bus.AEN    = v.aen;
    bus.A      = v.a;
    bus.DACK   = v.dack;
    bus.PG_WR  = v.wr;
    bus.PG_SEL = v.sel;
    bus.PG_DIN = v.din;
    @(posedge clk);
    #1;
    chk({tag, ".addr"}, 32'(bus.SYS_ADDR),   32'(v.e_addr));
    chk({tag, ".vld"},  32'(bus.ADDR_VALID), 32'(v.e_vld));
    chk({tag, ".bnd"},  32'(bus.BND_CROSS),  32'(v.e_bnd));
    chk({tag, ".err"},  32'(bus.DACK_ERR),   32'(v.e_err));
    chk({tag, ".dout"}, 32'(bus.PG_DOUT),    32'(v.e_dout));
  endtask

  initial begin
    // rst, adstb, db, aen, a, dack, wr, sel, din | addr, vld, bnd, err, dout
    // reset with strobe active, then a ch0 session shows hi_latch cleared
    tv.push_back(mk(0,1,8'hAA,0,8'h00,4'h0,0,2'd0,8'h00, 24'h000000,0,0,0,8'h00));
    tv.push_back(mk(0,1,8'hAA,0,8'h00,4'h0,0,2'd1,8'h00, 24'h000000,0,0,0,8'h00));
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,0,2'd2,8'h00, 24'h000000,0,0,0,8'h00));
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,0,2'd3,8'h00, 24'h000000,0,0,0,8'h00));
    tv.push_back(mk(1,0,8'h00,1,8'h00,4'h1,0,2'd0,8'h00, 24'h000000,0,0,0,8'h00));
    tv.push_back(mk(1,0,8'h00,1,8'h00,4'h1,0,2'd0,8'h00, 24'h000000,1,0,0,8'h00));
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,0,2'd0,8'h00, 24'h000000,0,0,0,8'h00));
    // basic ch2 service
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,1,2'd2,8'h12, 24'h000000,0,0,0,8'h12));
    tv.push_back(mk(1,0,8'h00,1,8'h00,4'h4,0,2'd2,8'h00, 24'h000000,0,0,0,8'h12));
    tv.push_back(mk(1,1,8'h34,1,8'h56,4'h4,0,2'd2,8'h00, 24'h123456,1,0,0,8'h12));
    tv.push_back(mk(1,0,8'h00,1,8'h56,4'h4,0,2'd2,8'h00, 24'h123456,1,0,0,8'h12));
    tv.push_back(mk(1,0,8'h00,1,8'h57,4'h4,0,2'd2,8'h00, 24'h123457,1,0,0,8'h12));
    tv.push_back(mk(1,0,8'h00,0,8'h57,4'h4,0,2'd2,8'h00, 24'h000000,0,0,0,8'h12));
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h6,0,2'd2,8'h00, 24'h000000,0,0,0,8'h12));
    // ch1 64K wrap: FF then 00, cleared by next session start
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,1,2'd1,8'hA5, 24'h000000,0,0,0,8'hA5));
    tv.push_back(mk(1,1,8'hFF,1,8'h10,4'h2,0,2'd1,8'h00, 24'h000000,0,0,0,8'hA5));
    tv.push_back(mk(1,0,8'h00,1,8'h11,4'h2,0,2'd1,8'h00, 24'hA5FF11,1,0,0,8'hA5));
    tv.push_back(mk(1,1,8'h00,1,8'h12,4'h2,0,2'd1,8'h00, 24'hA50012,1,1,0,8'hA5));
    tv.push_back(mk(1,0,8'h00,1,8'h13,4'h2,0,2'd1,8'h00, 24'hA50013,1,1,0,8'hA5));
    tv.push_back(mk(1,0,8'h00,0,8'h13,4'h2,0,2'd1,8'h00, 24'h000000,0,1,0,8'hA5));
    tv.push_back(mk(1,0,8'h00,1,8'h00,4'h2,0,2'd1,8'h00, 24'h000000,0,0,0,8'hA5));
    tv.push_back(mk(1,0,8'h00,1,8'h01,4'h2,0,2'd1,8'h00, 24'hA50001,1,0,0,8'hA5));
    // wrap again, then a page write to the active channel clears the flag
    tv.push_back(mk(1,1,8'hFF,1,8'h02,4'h2,0,2'd1,8'h00, 24'hA5FF02,1,0,0,8'hA5));
    tv.push_back(mk(1,1,8'h00,1,8'h04,4'h2,0,2'd1,8'h00, 24'hA50004,1,1,0,8'hA5));
    tv.push_back(mk(1,0,8'h00,1,8'h05,4'h2,1,2'd1,8'hA5, 24'hA50005,1,0,0,8'hA5));
    // FF captured before the session: first in-session 00 must not flag a wrap
    tv.push_back(mk(1,1,8'hFF,0,8'h00,4'h0,0,2'd1,8'h00, 24'h000000,0,0,0,8'hA5));
    tv.push_back(mk(1,0,8'h00,1,8'h00,4'h2,0,2'd1,8'h00, 24'h000000,0,0,0,8'hA5));
    tv.push_back(mk(1,1,8'h00,1,8'h03,4'h2,0,2'd1,8'h00, 24'hA50003,1,0,0,8'hA5));
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,0,2'd1,8'h00, 24'h000000,0,0,0,8'hA5));
    // bad DACK patterns and the DACK_ERR clear rule
    tv.push_back(mk(1,0,8'h00,1,8'h00,4'h6,0,2'd0,8'h00, 24'h000000,0,0,1,8'h00));
    tv.push_back(mk(1,1,8'h44,1,8'h55,4'h6,0,2'd0,8'h00, 24'h000000,0,0,1,8'h00));
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,0,2'd0,8'h00, 24'h000000,0,0,1,8'h00));
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,1,2'd0,8'h01, 24'h000000,0,0,1,8'h01));
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,1,2'd0,8'h00, 24'h000000,0,0,0,8'h00));
    tv.push_back(mk(1,0,8'h00,1,8'h00,4'h0,0,2'd0,8'h00, 24'h000000,0,0,1,8'h00));
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,0,2'd0,8'h00, 24'h000000,0,0,1,8'h00));
    tv.push_back(mk(1,0,8'h00,0,8'h00,4'h0,1,2'd0,8'h00, 24'h000000,0,0,0,8'h00));

    for (int i = 0; i < tv.size(); i++)
      step(tv[i], $sformatf("vec[%0d]", i));

    // deferred write to the active ch3; ch0 write commits at once
    step(mk(1,0,8'h00,0,8'h00,4'h0,1,2'd3,8'h33, 24'h000000,0,0,0,8'h33), "defer.setup");
    step(mk(1,0,8'h00,1,8'h00,4'h8,0,2'd3,8'h00, 24'h000000,0,0,0,8'h33), "defer.start");
    step(mk(1,1,8'h9A,1,8'h00,4'h8,0,2'd3,8'h00, 24'h339A00,1,0,0,8'h33), "defer.strobe");
    step(mk(1,0,8'h00,1,8'h01,4'h8,1,2'd3,8'h77, 24'h339A01,1,0,0,8'h33), "defer.wr3");
    step(mk(1,0,8'h00,1,8'h02,4'h8,1,2'd0,8'h05, 24'h339A02,1,0,0,8'h05), "defer.wr0");
    step(mk(1,0,8'h00,1,8'h03,4'h8,1,2'd3,8'h78, 24'h339A03,1,0,0,8'h33), "defer.wr3b");
    step(mk(1,0,8'h00,1,8'h04,4'h8,0,2'd3,8'h00, 24'h339A04,1,0,0,8'h33), "defer.hold");
    step(mk(1,0,8'h00,0,8'h00,4'h0,0,2'd3,8'h00, 24'h000000,0,0,0,8'h78), "defer.commit");

    // write on the AEN-falling edge commits directly
    step(mk(1,0,8'h00,1,8'h00,4'h8,0,2'd3,8'h00, 24'h000000,0,0,0,8'h78), "fall.start");
    step(mk(1,0,8'h00,1,8'h05,4'h8,0,2'd3,8'h00, 24'h789A05,1,0,0,8'h78), "fall.svc");
    step(mk(1,0,8'h00,0,8'h00,4'h0,1,2'd3,8'h79, 24'h000000,0,0,0,8'h79), "fall.wr");

    // reset in mid-session discards the pending write
    step(mk(1,0,8'h00,1,8'h00,4'h8,0,2'd3,8'h00, 24'h000000,0,0,0,8'h79), "rstmid.start");
    step(mk(1,1,8'hBC,1,8'h01,4'h8,0,2'd3,8'h00, 24'h79BC01,1,0,0,8'h79), "rstmid.svc");
    step(mk(1,0,8'h00,1,8'h02,4'h8,1,2'd3,8'h11, 24'h79BC02,1,0,0,8'h79), "rstmid.pend");
    step(mk(0,0,8'h00,1,8'h02,4'h8,0,2'd3,8'h00, 24'h000000,0,0,0,8'h00), "rstmid.rst");
    step(mk(1,0,8'h00,0,8'h00,4'h0,0,2'd3,8'h00, 24'h000000,0,0,0,8'h00), "rstmid.after");
    step(mk(1,0,8'h00,0,8'h00,4'h0,0,2'd0,8'h00, 24'h000000,0,0,0,8'h00), "rstmid.pg0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
